ex_unit: RTL and testbench
==========================

EX_UNIT -- requirements
Module: ex_unit

Interface
REQ-001 SHALL provide parameter DATA_W, default 32, operand/result width.
REQ-002 SHALL provide parameter REG_AW, default 5, register address width.
REQ-003 SHALL provide parameter MUL_LAT, default 4 (legal 1..16), multiply latency in cycles.
REQ-004 SHALL provide parameter CNT_W, default 32, taken-branch counter width.
REQ-005 SHALL have ports: clk  in  1  sole clock, all state on rising edge.
REQ-006 SHALL have ports: reset  in  1  asynchronous, active-low reset.
REQ-007 SHALL have ports: in_valid  in  1  ID/EX holds a valid instruction.
REQ-008 SHALL have ports: busy  out  1  multiply in flight; upstream holds ID/EX.
REQ-009 SHALL have ports: flush  in  1  taken branch in EX/DM; squash this stage.
REQ-010 SHALL have ports: rs_data, rt_data, imm, pc  in  DATA_W  operands, sign-extended immediate, PC.
REQ-011 SHALL have ports: rs_addr, rt_addr, rd_addr  in  REG_AW  source/destination register numbers.
REQ-012 SHALL have ports: alu_op  in  2  00 add, 01 beq/sub, 10 R-type, 11 reserved; alu_src, reg_dst, branch  in  1 each.
REQ-013 SHALL have ports: ctrl_in  in  4  {mem_read, mem_write, reg_write, mem_to_reg}.
REQ-014 SHALL have ports: fwd_dm_en/fwd_wb_en  in  1, fwd_dm_addr/fwd_wb_addr  in  REG_AW, fwd_dm_data/fwd_wb_data  in  DATA_W  EX/DM and DM/WB forwarding sources.
REQ-015 SHALL have ports: out_valid, branch_taken, zero, illegal  out  1; result, store_data, branch_target  out  DATA_W; dest  out  REG_AW; ctrl_out  out  4; branch_count  out  CNT_W.

Function
REQ-016 Operand A SHALL be fwd_dm_data when fwd_dm_en and fwd_dm_addr==rs_addr, else fwd_wb_data on DM/WB match, else rs_data; EX/DM wins on double match.
REQ-017 Address 0 SHALL never match a forwarding source.
REQ-018 Operand B SHALL be imm when alu_src=1 or alu_op=00, else rt_data forwarded per REQ-016 using rt_addr; store_data SHALL be the forwarded rt value regardless of alu_src.
REQ-019 R-type funct = imm[5:0]: 000000 add, 000001 sub, 000010 mul, 000011 and, 000100 or, 000101 slt (signed); any other funct, or alu_op=11, SHALL give result 0 and illegal=1.
REQ-020 Add/sub/mul SHALL be modulo 2^DATA_W; mul keeps the low DATA_W bits.
REQ-021 Non-mul ops SHALL register all outputs one cycle after the accepting edge (latency 1).
REQ-022 Mul SHALL use states IDLE -> MUL(count MUL_LAT-1 down to 0) -> IDLE; busy=1 throughout MUL; out_valid=0 until the final cycle, when result, dest and ctrl_out of the mul update with out_valid=1.
REQ-023 While busy=1, in_valid SHALL be ignored; operands SHALL be latched at entry to MUL.
REQ-024 dest SHALL be rt_addr when reg_dst=0, else rd_addr.
REQ-025 zero SHALL be 1 when operand A equals operand B.
REQ-026 When branch=1 and zero=1 on a valid instruction: branch_taken=1, branch_target=imm, branch_count increments, saturating at all-ones; otherwise branch_taken=0 and branch_target=pc.
REQ-027 When flush=1: out_valid, ctrl_out, branch_taken and illegal SHALL clear next edge; any multiply SHALL abort to IDLE; branch_count SHALL be held; flush has priority over in_valid.
REQ-028 When in_valid=0 and not busy: out_valid=0 and ctrl_out=0; data outputs SHALL hold.

Reset
REQ-029 reset low SHALL immediately force all outputs to 0, busy=0, state IDLE, branch_count=0, independent of clk.
REQ-030 Reset asserted mid-multiply SHALL discard the operation; the first edge after release SHALL accept a new instruction.

Configuration
REQ-031 With EX_MUL_EN defined: multiply per REQ-022. Without it: funct 000010 SHALL be illegal (result 0, illegal=1, latency 1), busy SHALL tie to 0, and no multiplier or MUL state SHALL be built.

Verification
REQ-032 add r3 from rs=5, rt=7, no forwarding -> next cycle result=12, dest=3, out_valid=1.
REQ-033 rs_addr=2, both fwd_dm (data 0x10) and fwd_wb (data 0x20) target r2 -> operand A=0x10; same case with address 0 -> rs_data used.
REQ-034 mul 6*7 with MUL_LAT=4 -> busy high 4 cycles, out_valid only in the last, result=42; held in_valid during busy not consumed.
REQ-035 beq with equal operands, imm=0x40, branch_count=all-ones -> branch_taken=1, branch_target=0x40, count stays all-ones.
REQ-036 flush asserted in cycle 2 of a multiply -> busy drops next edge, out_valid=0, ctrl_out=0; reset pulse mid-multiply -> all outputs 0 asynchronously.
REQ-037 Build without EX_MUL_EN, issue funct 000010 -> result=0, illegal=1, busy never asserted.

Source files
------------

// File: rtl/ex_unit.sv
// ex_unit: execute stage with operand forwarding, ALU, branch resolution and taken-branch counter.
// Optional macro EX_MUL_EN builds the MUL_LAT-cycle multiplier; without it funct 000010 decodes as illegal.
module ex_unit #(
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned REG_AW  = 5,
  parameter int unsigned MUL_LAT = 4,
  parameter int unsigned CNT_W   = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              busy,
  input  logic              flush,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic [DATA_W-1:0] imm,
  input  logic [DATA_W-1:0] pc,
  input  logic [REG_AW-1:0] rs_addr,
  input  logic [REG_AW-1:0] rt_addr,
  input  logic [REG_AW-1:0] rd_addr,
  input  logic [1:0]        alu_op,
  input  logic              alu_src,
  input  logic              reg_dst,
  input  logic              branch,
  input  logic [3:0]        ctrl_in,
  input  logic              fwd_dm_en,
  input  logic              fwd_wb_en,
  input  logic [REG_AW-1:0] fwd_dm_addr,
  input  logic [REG_AW-1:0] fwd_wb_addr,
  input  logic [DATA_W-1:0] fwd_dm_data,
  input  logic [DATA_W-1:0] fwd_wb_data,
  output logic              out_valid,
  output logic              branch_taken,
  output logic              zero,
  output logic              illegal,
  output logic [DATA_W-1:0] result,
  output logic [DATA_W-1:0] store_data,
  output logic [DATA_W-1:0] branch_target,
  output logic [REG_AW-1:0] dest,
  output logic [3:0]        ctrl_out,
  output logic [CNT_W-1:0]  branch_count
);

  localparam int unsigned CTRL_W = 4;
  localparam int unsigned FN_W   = 6;
  localparam int unsigned LAT_W  = 4;
  localparam logic [FN_W-1:0] FN_ADD = 6'd0;
  localparam logic [FN_W-1:0] FN_SUB = 6'd1;
  localparam logic [FN_W-1:0] FN_AND = 6'd3;
  localparam logic [FN_W-1:0] FN_OR  = 6'd4;
  localparam logic [FN_W-1:0] FN_SLT = 6'd5;

  if (MUL_LAT < 1 || MUL_LAT > 16) begin : g_lat_check
    $error("ex_unit: MUL_LAT must be in 1..16");
  end

  logic [DATA_W-1:0] op_a, op_b, rt_fwd, alu_res;
  logic              alu_ill, dm_rs, wb_rs, dm_rt, wb_rt;
  logic [REG_AW-1:0] dest_sel;
  logic [FN_W-1:0]   funct;

  logic              out_valid_d, taken_d, zero_d, illegal_d;
  logic [DATA_W-1:0] result_d, store_d, target_d;
  logic [REG_AW-1:0] dest_d;
  logic [CTRL_W-1:0] ctrl_d;
  logic [CNT_W-1:0]  count_d;

`ifdef EX_MUL_EN
  localparam logic [FN_W-1:0] FN_MUL = 6'd2;
  typedef enum logic {S_IDLE = 1'b0, S_MUL = 1'b1} state_t;
  state_t            state_q, state_d;
  logic [LAT_W-1:0]  cnt_q, cnt_d;
  logic [DATA_W-1:0] mul_a_q, mul_a_d, mul_b_q, mul_b_d;
  logic [REG_AW-1:0] mul_dest_q, mul_dest_d;
  logic [CTRL_W-1:0] mul_ctrl_q, mul_ctrl_d;
  logic              is_mul;
`endif

  // Forwarding: EX/DM beats DM/WB, register 0 is never forwarded.
  always_comb begin : fwd_mux
    dm_rs    = fwd_dm_en && (rs_addr != '0) && (fwd_dm_addr == rs_addr);
    wb_rs    = fwd_wb_en && (rs_addr != '0) && (fwd_wb_addr == rs_addr);
    dm_rt    = fwd_dm_en && (rt_addr != '0) && (fwd_dm_addr == rt_addr);
    wb_rt    = fwd_wb_en && (rt_addr != '0) && (fwd_wb_addr == rt_addr);
    op_a     = dm_rs ? fwd_dm_data : (wb_rs ? fwd_wb_data : rs_data);
    rt_fwd   = dm_rt ? fwd_dm_data : (wb_rt ? fwd_wb_data : rt_data);
    op_b     = (alu_src || alu_op == 2'b00) ? imm : rt_fwd;
    dest_sel = reg_dst ? rd_addr : rt_addr;
    funct    = imm[FN_W-1:0];
  end

  // Single-cycle ALU; illegal encodings yield zero.
  always_comb begin : alu
    alu_res = '0;
    alu_ill = 1'b0;
`ifdef EX_MUL_EN
    is_mul  = 1'b0;
`endif
    case (alu_op)
      2'b00: alu_res = op_a + op_b;
      2'b01: alu_res = op_a - op_b;
      2'b10: begin
        case (funct)
          FN_ADD:  alu_res = op_a + op_b;
          FN_SUB:  alu_res = op_a - op_b;
          FN_AND:  alu_res = op_a & op_b;
          FN_OR:   alu_res = op_a | op_b;
          FN_SLT:  alu_res = DATA_W'($signed(op_a) < $signed(op_b));
`ifdef EX_MUL_EN
          FN_MUL:  is_mul = 1'b1;
`endif
          default: alu_ill = 1'b1;
        endcase
      end
      default: alu_ill = 1'b1;
    endcase
  end

  // Next-state and next-output decode; control outputs default low, data outputs hold.
  always_comb begin : next_out
    out_valid_d = 1'b0;
    ctrl_d      = '0;
    taken_d     = 1'b0;
    illegal_d   = 1'b0;
    result_d    = result;
    store_d     = store_data;
    target_d    = branch_target;
    dest_d      = dest;
    zero_d      = zero;
    count_d     = branch_count;
`ifdef EX_MUL_EN
    state_d     = state_q;
    cnt_d       = cnt_q;
    mul_a_d     = mul_a_q;
    mul_b_d     = mul_b_q;
    mul_dest_d  = mul_dest_q;
    mul_ctrl_d  = mul_ctrl_q;
    if (flush) begin
      state_d = S_IDLE;
    end else if (state_q == S_MUL) begin
      // Result is published in the last MUL cycle (count reaches 0).
      if (cnt_q == LAT_W'(1)) begin
        out_valid_d = 1'b1;
        result_d    = DATA_W'(mul_a_q * mul_b_q);
        dest_d      = mul_dest_q;
        ctrl_d      = mul_ctrl_q;
      end
      if (cnt_q == '0) state_d = S_IDLE;
      else             cnt_d   = cnt_q - LAT_W'(1);
    end else if (in_valid && is_mul) begin
      state_d    = S_MUL;
      cnt_d      = LAT_W'(MUL_LAT - 1);
      mul_a_d    = op_a;
      mul_b_d    = op_b;
      mul_dest_d = dest_sel;
      mul_ctrl_d = ctrl_in;
      if (MUL_LAT == 1) begin
        out_valid_d = 1'b1;
        result_d    = DATA_W'(op_a * op_b);
        dest_d      = dest_sel;
        ctrl_d      = ctrl_in;
      end
    end else
`endif
    if (!flush && in_valid) begin
      out_valid_d = 1'b1;
      ctrl_d      = ctrl_in;
      result_d    = alu_res;
      illegal_d   = alu_ill;
      store_d     = rt_fwd;
      dest_d      = dest_sel;
      zero_d      = (op_a == op_b);
      target_d    = pc;
      if (branch && (op_a == op_b)) begin
        taken_d  = 1'b1;
        target_d = imm;
        if (~&branch_count) count_d = branch_count + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin : out_regs
    if (!reset) begin
      out_valid     <= 1'b0;
      ctrl_out      <= '0;
      branch_taken  <= 1'b0;
      illegal       <= 1'b0;
      result        <= '0;
      store_data    <= '0;
      branch_target <= '0;
      dest          <= '0;
      zero          <= 1'b0;
      branch_count  <= '0;
    end else begin
      out_valid     <= out_valid_d;
      ctrl_out      <= ctrl_d;
      branch_taken  <= taken_d;
      illegal       <= illegal_d;
      result        <= result_d;
      store_data    <= store_d;
      branch_target <= target_d;
      dest          <= dest_d;
      zero          <= zero_d;
      branch_count  <= count_d;
    end
  end

`ifdef EX_MUL_EN
  always_ff @(posedge clk or negedge reset) begin : mul_regs
    if (!reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      mul_a_q    <= '0;
      mul_b_q    <= '0;
      mul_dest_q <= '0;
      mul_ctrl_q <= '0;
      busy       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      mul_a_q    <= mul_a_d;
      mul_b_q    <= mul_b_d;
      mul_dest_q <= mul_dest_d;
      mul_ctrl_q <= mul_ctrl_d;
      busy       <= (state_d == S_MUL);
    end
  end
`else
  assign busy = 1'b0;
`endif

endmodule

// File: tb/tb_ex_unit.sv
// Directed self-checking bench for ex_unit (MUL_LAT=4, CNT_W=2 so the branch counter saturates quickly).
module tb_ex_unit;
  localparam int unsigned DATA_W = 32;
  localparam int unsigned REG_AW = 5;
  localparam int unsigned MUL_LAT = 4;
  localparam int unsigned CNT_W = 2;

  logic clk = 1'b0;
  logic reset, in_valid, flush, alu_src, reg_dst, branch;
  logic fwd_dm_en, fwd_wb_en;
  logic [DATA_W-1:0] rs_data, rt_data, imm, pc, fwd_dm_data, fwd_wb_data;
  logic [REG_AW-1:0] rs_addr, rt_addr, rd_addr, fwd_dm_addr, fwd_wb_addr;
  logic [1:0] alu_op;
  logic [3:0] ctrl_in;
  logic busy, out_valid, branch_taken, zero, illegal;
  logic [DATA_W-1:0] result, store_data, branch_target;
  logic [REG_AW-1:0] dest;
  logic [3:0] ctrl_out;
  logic [CNT_W-1:0] branch_count;

  int checks = 0;
  int errors = 0;

  ex_unit #(.DATA_W(DATA_W), .REG_AW(REG_AW), .MUL_LAT(MUL_LAT), .CNT_W(CNT_W)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .busy(busy), .flush(flush),
    .rs_data(rs_data), .rt_data(rt_data), .imm(imm), .pc(pc),
    .rs_addr(rs_addr), .rt_addr(rt_addr), .rd_addr(rd_addr),
    .alu_op(alu_op), .alu_src(alu_src), .reg_dst(reg_dst), .branch(branch), .ctrl_in(ctrl_in),
    .fwd_dm_en(fwd_dm_en), .fwd_wb_en(fwd_wb_en), .fwd_dm_addr(fwd_dm_addr), .fwd_wb_addr(fwd_wb_addr),
    .fwd_dm_data(fwd_dm_data), .fwd_wb_data(fwd_wb_data),
    .out_valid(out_valid), .branch_taken(branch_taken), .zero(zero), .illegal(illegal),
    .result(result), .store_data(store_data), .branch_target(branch_target),
    .dest(dest), .ctrl_out(ctrl_out), .branch_count(branch_count)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    in_valid = 0; flush = 0; alu_src = 0; reg_dst = 1; branch = 0;
    fwd_dm_en = 0; fwd_wb_en = 0; fwd_dm_addr = 0; fwd_wb_addr = 0;
    fwd_dm_data = 0; fwd_wb_data = 0; rs_data = 0; rt_data = 0; imm = 0; pc = 32'h100;
    rs_addr = 0; rt_addr = 0; rd_addr = 0; alu_op = 0; ctrl_in = 0;
  endtask

  task automatic set_op(input logic [1:0] op, input logic [31:0] immv,
                        input logic [4:0] ra, input logic [31:0] da,
                        input logic [4:0] rb, input logic [31:0] db, input logic [4:0] rd);
    in_valid = 1; alu_op = op; alu_src = 0; reg_dst = 1; branch = 0; ctrl_in = 4'b0010;
    imm = immv; rs_addr = ra; rs_data = da; rt_addr = rb; rt_data = db; rd_addr = rd;
  endtask

  task automatic test_reset();
    reset = 1; clear_inputs();
    #1 reset = 0;
    #2;
    checks++;
    if ({out_valid, busy, branch_taken, zero, illegal, result, store_data, branch_target,
         dest, ctrl_out, branch_count} !== '0) begin
      errors++; $display("FAIL reset_state: ov=%b busy=%b res=%h cnt=%0d required all zero",
                         out_valid, busy, result, branch_count);
    end
    tick(); tick();
    checks++;
    if ({out_valid, busy, result, ctrl_out} !== '0) begin
      errors++; $display("FAIL reset_held: ov=%b busy=%b res=%h required zero", out_valid, busy, result);
    end
    #2 reset = 1;
  endtask

  typedef struct { logic [1:0] op; logic [31:0] immv, a, b, exp; logic ill; } vec_t;

  task automatic test_alu();
    vec_t v[10];
    v[0] = '{2'b10, 32'd0, 32'd5, 32'd7, 32'd12, 1'b0};
    v[1] = '{2'b10, 32'd1, 32'd5, 32'd7, 32'hFFFF_FFFE, 1'b0};
    v[2] = '{2'b10, 32'd3, 32'h0000_F0F0, 32'h0000_0FF0, 32'h0000_00F0, 1'b0};
    v[3] = '{2'b10, 32'd4, 32'h0000_F000, 32'h0000_000F, 32'h0000_F00F, 1'b0};
    v[4] = '{2'b10, 32'd0, 32'hFFFF_FFFF, 32'd1, 32'd0, 1'b0};
    v[5] = '{2'b00, 32'd100, 32'd5, 32'd7, 32'd105, 1'b0};
    v[6] = '{2'b11, 32'd0, 32'd5, 32'd7, 32'd0, 1'b1};
    v[7] = '{2'b10, 32'h3F, 32'd5, 32'd7, 32'd0, 1'b1};
    v[8] = '{2'b10, 32'd5, 32'd1, 32'hFFFF_FFFF, 32'd0, 1'b0};
    v[9] = '{2'b10, 32'd5, 32'hFFFF_FFFF, 32'd1, 32'd1, 1'b0};
    for (int i = 0; i < 10; i++) begin
      set_op(v[i].op, v[i].immv, 5'd1, v[i].a, 5'd2, v[i].b, 5'd3);
      tick();
      checks++;
      if ({out_valid, illegal, result, dest, ctrl_out} !== {1'b1, v[i].ill, v[i].exp, 5'd3, 4'b0010}) begin
        errors++; $display("FAIL alu_vec%0d: ov=%b ill=%b res=%h dest=%0d required ov=1 ill=%b res=%h dest=3",
                           i, out_valid, illegal, result, dest, v[i].ill, v[i].exp);
      end
    end
    // reg_dst=0 selects rt; store_data carries rt even with an immediate operand
    set_op(2'b00, 32'd8, 5'd1, 32'd2, 5'd6, 32'hABCD, 5'd3);
    reg_dst = 0; alu_src = 1;
    tick();
    checks++;
    if ({result, dest, store_data} !== {32'd10, 5'd6, 32'hABCD}) begin
      errors++; $display("FAIL addi_dest_store: res=%h dest=%0d sd=%h required 0000000a 6 0000abcd",
                         result, dest, store_data);
    end
    in_valid = 0;
    tick();
    checks++;
    if ({out_valid, ctrl_out, result} !== {1'b0, 4'b0000, 32'd10}) begin
      errors++; $display("FAIL idle_hold: ov=%b ctrl=%b res=%h required 0 0000 0000000a", out_valid, ctrl_out, result);
    end
  endtask

  task automatic test_forwarding();
    set_op(2'b10, 32'd0, 5'd2, 32'h100, 5'd4, 32'd0, 5'd3);
    fwd_dm_en = 1; fwd_dm_addr = 2; fwd_dm_data = 32'h10;
    fwd_wb_en = 1; fwd_wb_addr = 2; fwd_wb_data = 32'h20;
    tick();
    checks++;
    if (result !== 32'h10) begin errors++; $display("FAIL fwd_dm_priority: res=%h required 00000010", result); end
    fwd_dm_en = 0;
    tick();
    checks++;
    if (result !== 32'h20) begin errors++; $display("FAIL fwd_wb: res=%h required 00000020", result); end
    fwd_dm_en = 1; rs_addr = 0; fwd_dm_addr = 0; fwd_wb_addr = 0;
    tick();
    checks++;
    if (result !== 32'h100) begin errors++; $display("FAIL fwd_r0: res=%h required 00000100", result); end
    set_op(2'b10, 32'd0, 5'd1, 32'd0, 5'd2, 32'h55, 5'd3);
    fwd_dm_addr = 2; fwd_wb_addr = 2; alu_src = 1;
    tick();
    checks++;
    if ({result, store_data} !== {32'h0, 32'h10}) begin
      errors++; $display("FAIL fwd_rt_store: res=%h sd=%h required 00000000 00000010", result, store_data);
    end
    fwd_dm_en = 0; fwd_wb_en = 0; in_valid = 0;
    tick();
  endtask

  task automatic beq(input logic [31:0] a, input logic [31:0] b);
    set_op(2'b01, 32'h40, 5'd1, a, 5'd2, b, 5'd3);
    branch = 1; pc = 32'h1000; ctrl_in = 4'b0000;
  endtask

  task automatic test_branch();
    beq(32'd9, 32'd9);
    tick();
    checks++;
    if ({branch_taken, zero, branch_target, branch_count} !== {1'b1, 1'b1, 32'h40, 2'd1}) begin
      errors++; $display("FAIL beq_taken: bt=%b z=%b tgt=%h cnt=%0d required 1 1 00000040 1",
                         branch_taken, zero, branch_target, branch_count);
    end
    beq(32'd9, 32'd8);
    tick();
    checks++;
    if ({branch_taken, zero, branch_target, branch_count} !== {1'b0, 1'b0, 32'h1000, 2'd1}) begin
      errors++; $display("FAIL beq_not_taken: bt=%b z=%b tgt=%h cnt=%0d required 0 0 00001000 1",
                         branch_taken, zero, branch_target, branch_count);
    end
  endtask

  task automatic test_flush();
    beq(32'd9, 32'd9);
    ctrl_in = 4'b1010; flush = 1;
    tick();
    checks++;
    if ({out_valid, ctrl_out, branch_taken, illegal, branch_count} !== {1'b0, 4'b0, 1'b0, 1'b0, 2'd1}) begin
      errors++; $display("FAIL flush_squash: ov=%b ctrl=%b bt=%b cnt=%0d required 0 0000 0 1",
                         out_valid, ctrl_out, branch_taken, branch_count);
    end
    flush = 0;
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 3; i++) begin
      beq(32'd4, 32'd4);
      tick();
      checks++;
      if ({branch_taken, branch_target, branch_count} !== {1'b1, 32'h40, 2'd3 - 2'(i == 0)}) begin
        errors++; $display("FAIL beq_saturate%0d: bt=%b tgt=%h cnt=%0d required 1 00000040 %0d",
                           i, branch_taken, branch_target, branch_count, (i == 0) ? 2 : 3);
      end
    end
    in_valid = 0; branch = 0;
    tick();
  endtask

`ifdef EX_MUL_EN
  task automatic test_mul();
    int busy_n, ov_n;
    busy_n = 0; ov_n = 0;
    set_op(2'b10, 32'd2, 5'd1, 32'd6, 5'd2, 32'd7, 5'd9);
    tick();
    // a different instruction is held on the inputs while the multiply runs
    set_op(2'b10, 32'd0, 5'd1, 32'd1, 5'd2, 32'd1, 5'd5);
    for (int i = 0; i < 4; i++) begin
      if (busy) busy_n++;
      if (out_valid) ov_n++;
      if (i == 3) begin
        checks++;
        if ({out_valid, result, dest, ctrl_out} !== {1'b1, 32'd42, 5'd9, 4'b0010}) begin
          errors++; $display("FAIL mul_result: ov=%b res=%h dest=%0d required 1 0000002a 9", out_valid, result, dest);
        end
      end
      tick();
    end
    checks++;
    if ({busy_n, ov_n} !== {32'd4, 32'd1}) begin
      errors++; $display("FAIL mul_timing: busy_cycles=%0d ov_cycles=%0d required 4 1", busy_n, ov_n);
    end
    checks++;
    if ({busy, out_valid, result} !== {1'b0, 1'b0, 32'd42}) begin
      errors++; $display("FAIL mul_held_ignored: busy=%b ov=%b res=%h required 0 0 0000002a", busy, out_valid, result);
    end
    set_op(2'b10, 32'd2, 5'd1, 32'h0001_0000, 5'd2, 32'h0001_0003, 5'd9);
    tick();
    in_valid = 0;
    tick(); tick(); tick();
    checks++;
    if ({out_valid, result} !== {1'b1, 32'h0003_0000}) begin
      errors++; $display("FAIL mul_wrap: ov=%b res=%h required 1 00030000", out_valid, result);
    end
    tick();
  endtask

  task automatic test_mul_abort();
    set_op(2'b10, 32'd2, 5'd1, 32'd6, 5'd2, 32'd7, 5'd9);
    tick();
    in_valid = 0;
    tick();
    flush = 1;
    tick();
    checks++;
    if ({busy, out_valid, ctrl_out} !== {1'b0, 1'b0, 4'b0}) begin
      errors++; $display("FAIL mul_flush: busy=%b ov=%b ctrl=%b required 0 0 0000", busy, out_valid, ctrl_out);
    end
    flush = 0;
    tick(); tick();
    checks++;
    if ({busy, out_valid, result} !== {1'b0, 1'b0, 32'h0003_0000}) begin
      errors++; $display("FAIL mul_flush_no_late: busy=%b ov=%b res=%h required 0 0 00030000", busy, out_valid, result);
    end
    set_op(2'b10, 32'd2, 5'd1, 32'd3, 5'd2, 32'd5, 5'd9);
    tick();
    in_valid = 0;
    tick();
    #1 reset = 0;
    #1;
    checks++;
    if ({out_valid, busy, branch_taken, zero, illegal, result, store_data, branch_target,
         dest, ctrl_out, branch_count} !== '0) begin
      errors++; $display("FAIL mul_async_reset: busy=%b res=%h cnt=%0d required all zero", busy, result, branch_count);
    end
    #1 reset = 1;
    set_op(2'b10, 32'd0, 5'd1, 32'd2, 5'd2, 32'd3, 5'd4);
    tick();
    checks++;
    if ({busy, out_valid, result, dest} !== {1'b0, 1'b1, 32'd5, 5'd4}) begin
      errors++; $display("FAIL post_reset_accept: busy=%b ov=%b res=%h dest=%0d required 0 1 00000005 4",
                         busy, out_valid, result, dest);
    end
    in_valid = 0;
  endtask
`else
  task automatic test_mul_disabled();
    int busy_seen;
    busy_seen = 0;
    set_op(2'b10, 32'd2, 5'd1, 32'd6, 5'd2, 32'd7, 5'd9);
    tick();
    if (busy) busy_seen++;
    checks++;
    if ({out_valid, illegal, result} !== {1'b1, 1'b1, 32'd0}) begin
      errors++; $display("FAIL mul_disabled: ov=%b ill=%b res=%h required 1 1 00000000", out_valid, illegal, result);
    end
    tick();
    if (busy) busy_seen++;
    in_valid = 0;
    tick();
    if (busy) busy_seen++;
    checks++;
    if (busy_seen !== 0) begin
      errors++; $display("FAIL mul_disabled_busy: busy_cycles=%0d required 0", busy_seen);
    end
  endtask
`endif

  initial begin
    test_reset();
    test_alu();
    test_forwarding();
    test_branch();
    test_flush();
    test_back_to_back();
`ifdef EX_MUL_EN
    test_mul();
    test_mul_abort();
`else
    test_mul_disabled();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
